// File: rtl/ioctl_loader.sv
`default_nettype none
// ioctl_loader: streams 'length' source bytes into an ioctl download port, framed by
// PRE_CYC/POST_CYC window cycles and spaced by WR_GAP idle cycles (rev 1.0).
module ioctl_loader #(
   parameter int unsigned WR_GAP   = 4,
   parameter int unsigned PRE_CYC  = 2,
   parameter int unsigned POST_CYC = 2
) (
   input  logic        clk_sys,
   input  logic        RESET,
   input  logic        start,
   input  logic [7:0]  index,
   input  logic [24:0] length,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   input  logic        ioctl_wait,
   output logic        ioctl_download,
   output logic [7:0]  ioctl_index,
   output logic        ioctl_wr,
   output logic [24:0] ioctl_addr,
   output logic [7:0]  ioctl_dout,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0] PRE_LAST  = 8'(PRE_CYC - 1);
   localparam logic [7:0] POST_LAST = 8'(POST_CYC - 1);
   localparam logic [7:0] GAP_LAST  = (WR_GAP > 0) ? 8'(WR_GAP - 1) : 8'd0;
   localparam bit         HAS_GAP   = (WR_GAP > 0);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      FETCH = 3'd2,
      WRITE = 3'd3,
      GAP   = 3'd4,
      TAIL  = 3'd5
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  timer;
   logic        timer_en;
   logic [24:0] count;
   logic [24:0] count_inc;
   logic [24:0] len;

   assign count_inc      = count + 25'd1;
   assign ioctl_download = (state != IDLE);
   assign busy           = (state != IDLE);
   assign ioctl_wr       = (state == WRITE);

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      timer_en  = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = ARM;
         end
         ARM: begin
            timer_en = 1'b1;
            if (timer == PRE_LAST) state_nxt = (len != 25'd0) ? FETCH : TAIL;
         end
         FETCH: begin
            s_ready = ~ioctl_wait;
            if (s_valid && !ioctl_wait) state_nxt = WRITE;
         end
         WRITE: begin
            // Without a gap the next-byte decision uses the post-increment count.
            if (HAS_GAP) state_nxt = GAP;
            else         state_nxt = (count_inc < len) ? FETCH : TAIL;
         end
         GAP: begin
            if (!ioctl_wait) begin
               timer_en = 1'b1;
               if (timer == GAP_LAST) state_nxt = (count < len) ? FETCH : TAIL;
            end
         end
         TAIL: begin
            timer_en = 1'b1;
            if (timer == POST_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         timer       <= 8'd0;
         count       <= 25'd0;
         len         <= 25'd0;
         ioctl_index <= 8'd0;
         ioctl_addr  <= 25'd0;
         ioctl_dout  <= 8'd0;
         done        <= 1'b0;
      end else begin
         done <= (state == TAIL) && (state_nxt == IDLE);
         // One timer serves ARM, GAP and TAIL; it restarts on every state change.
         if (state_nxt != state) timer <= 8'd0;
         else if (timer_en)      timer <= timer + 8'd1;
         if (state == IDLE && start) begin
            len         <= length;
            ioctl_index <= index;
            count       <= 25'd0;
         end
         if (state == FETCH && s_valid && !ioctl_wait) begin
            ioctl_dout <= s_data;
            ioctl_addr <= count;
         end
         if (state == WRITE) count <= count_inc;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ioctl_loader.sv
`default_nettype none
// Bench for ioctl_loader: a per-download timeline model built from the stimulus
// patterns, compared against the DUT every cycle, plus literal timing pins.
module tb_ioctl_loader;
   localparam int WR_GAP   = 4;
   localparam int PRE_CYC  = 2;
   localparam int POST_CYC = 2;
   localparam int MAXC     = 512;

   logic        clk_sys = 1'b0;
   logic        RESET, start, s_valid, s_ready, ioctl_wait;
   logic        ioctl_download, ioctl_wr, busy, done;
   logic [7:0]  index, s_data, ioctl_index, ioctl_dout;
   logic [24:0] length, ioctl_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_sys = ~clk_sys;

   ioctl_loader #(.WR_GAP(WR_GAP), .PRE_CYC(PRE_CYC), .POST_CYC(POST_CYC)) dut (
      .clk_sys(clk_sys), .RESET(RESET), .start(start), .index(index), .length(length),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .ioctl_wait(ioctl_wait),
      .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .busy(busy), .done(done)
   );

   // Stimulus patterns and expected timeline, indexed by cycle within a download.
   bit          valid_pat[MAXC];
   bit          wait_pat[MAXC];
   bit          start_pat[MAXC];
   logic [7:0]  idx_pat[MAXC];
   logic [7:0]  src[64];
   bit          e_dl[MAXC], e_wr[MAXC], e_rdy[MAXC], e_done[MAXC];
   logic [24:0] e_addr[MAXC];
   logic [7:0]  e_dout[MAXC], e_idx[MAXC];
   logic [24:0] m_addr = 25'd0;
   logic [7:0]  m_dout = 8'd0, m_idx = 8'd0;
   int          rst_at, win, done_at, cyc;
   bit          chk_on = 1'b0;
   int          wr_cyc[$];
   int          wr_addr[$];
   int          done_cyc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int wr_at(input int i);
      return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
   endfunction

   function automatic int done_first();
      return (done_cyc.size() > 0) ? done_cyc[0] : -1;
   endfunction

   always @(negedge clk_sys) begin
      if (chk_on) begin
         check("download", 32'(ioctl_download), 32'(e_dl[cyc]));
         check("busy",     32'(busy),           32'(e_dl[cyc]));
         check("wr",       32'(ioctl_wr),       32'(e_wr[cyc]));
         check("s_ready",  32'(s_ready),        32'(e_rdy[cyc]));
         check("done",     32'(done),           32'(e_done[cyc]));
         check("addr",     32'(ioctl_addr),     32'(e_addr[cyc]));
         check("dout",     32'(ioctl_dout),     32'(e_dout[cyc]));
         check("index",    32'(ioctl_index),    32'(e_idx[cyc]));
         if (ioctl_wr) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(ioctl_addr));
         end
         if (done) done_cyc.push_back(cyc);
      end
   end

   task automatic clear_pats();
      for (int i = 0; i < MAXC; i++) begin
         valid_pat[i] = 1'b1;
         wait_pat[i]  = 1'b0;
         start_pat[i] = 1'b0;
         idx_pat[i]   = 8'($urandom);
      end
      for (int i = 0; i < 64; i++) src[i] = 8'($urandom);
      rst_at = -1;
      wr_cyc.delete();
      wr_addr.delete();
      done_cyc.delete();
   endtask

   // Walk the download as a sequence of phases: window open, per byte wait for a
   // handshake then write then count unstalled gap cycles, window close, done.
   task automatic build_model(input int len, input logic [7:0] idx);
      int t, g, k;
      logic [24:0] a;
      logic [7:0]  d, ix;
      for (int i = 0; i < MAXC; i++) begin
         e_dl[i] = 0; e_wr[i] = 0; e_rdy[i] = 0; e_done[i] = 0;
      end
      t = 1;
      repeat (PRE_CYC) begin e_dl[t] = 1; t++; end
      for (k = 0; k < len; k++) begin
         while (!(valid_pat[t] && !wait_pat[t]) && t < MAXC - 64) begin
            e_dl[t] = 1; e_rdy[t] = !wait_pat[t]; t++;
         end
         e_dl[t] = 1; e_rdy[t] = 1; t++;
         e_dl[t] = 1; e_wr[t] = 1; t++;
         g = 0;
         while (g < WR_GAP && t < MAXC - 64) begin
            e_dl[t] = 1;
            if (!wait_pat[t]) g++;
            t++;
         end
      end
      repeat (POST_CYC) begin e_dl[t] = 1; t++; end
      e_done[t] = 1;
      done_at = t;
      win = t + 3;
      a = m_addr; d = m_dout; ix = m_idx; k = 0;
      for (int c = 0; c < MAXC; c++) begin
         if (c == 1) ix = idx;
         if (e_wr[c]) begin a = 25'(k); d = src[k]; k++; end
         if (rst_at >= 0 && c > rst_at) begin
            e_dl[c] = 0; e_wr[c] = 0; e_rdy[c] = 0; e_done[c] = 0;
            a = 25'd0; d = 8'd0; ix = 8'd0;
         end
         e_addr[c] = a; e_dout[c] = d; e_idx[c] = ix;
      end
      if (rst_at >= 0 && rst_at + 3 < win) win = rst_at + 3;
      m_addr = e_addr[win - 1];
      m_dout = e_dout[win - 1];
      m_idx  = e_idx[win - 1];
   endtask

   task automatic run(input int len, input logic [7:0] idx, input bit rnd_starts);
      int acc, lim;
      build_model(len, idx);
      start_pat[0] = 1'b1;
      idx_pat[0]   = idx;
      lim = done_at;
      if (rst_at >= 0 && rst_at < lim) lim = rst_at;
      if (rnd_starts)
         for (int c = 1; c < lim; c++) if ($urandom_range(7) == 0) start_pat[c] = 1'b1;
      acc = 0;
      for (int c = 0; c < win; c++) begin
         @(posedge clk_sys); #1;
         cyc        = c;
         chk_on     = 1'b1;
         RESET      = (c == rst_at);
         start      = start_pat[c];
         index      = idx_pat[c];
         length     = (c == 0) ? 25'(len) : 25'($urandom);
         s_valid    = valid_pat[c];
         ioctl_wait = wait_pat[c];
         s_data     = (acc < 64) ? src[acc] : 8'h00;
         #3;
         if (s_valid && s_ready) acc++;
      end
      @(posedge clk_sys); #1;
      chk_on = 1'b0;
      RESET  = 1'b0;
      start  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; start = 1'b0; index = 8'd0; length = 25'd0;
      s_valid = 1'b0; s_data = 8'd0; ioctl_wait = 1'b0; cyc = 0; rst_at = -1;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check("rst_download", 32'(ioctl_download), 32'd0);
      check("rst_wr",       32'(ioctl_wr),       32'd0);
      check("rst_addr",     32'(ioctl_addr),     32'd0);
      check("rst_dout",     32'(ioctl_dout),     32'd0);
      check("rst_index",    32'(ioctl_index),    32'd0);
      check("rst_s_ready",  32'(s_ready),        32'd0);
      check("rst_busy",     32'(busy),           32'd0);
      check("rst_done",     32'(done),           32'd0);
      @(posedge clk_sys); #1;
      RESET = 1'b0;

      // Basic three-byte download.
      clear_pats();
      src[0] = 8'hA0; src[1] = 8'hA1; src[2] = 8'hA2;
      run(3, 8'h00, 1'b0);
      check("t1_wr_count", 32'(wr_cyc.size()), 32'd3);
      check("t1_wr0_cyc",  32'(wr_at(0)), 32'd4);
      check("t1_wr1_cyc",  32'(wr_at(1)), 32'd10);
      check("t1_wr2_cyc",  32'(wr_at(2)), 32'd16);
      check("t1_done_cyc", 32'(done_first()), 32'd23);

      // Zero-length download.
      clear_pats();
      run(0, 8'h5A, 1'b0);
      check("t2_wr_count", 32'(wr_cyc.size()), 32'd0);
      check("t2_done_cyc", 32'(done_first()), 32'(PRE_CYC + POST_CYC + 1));

      // Back-pressure for five cycles in the first gap.
      clear_pats();
      for (int i = 5; i <= 9; i++) wait_pat[i] = 1'b1;
      run(3, 8'h22, 1'b0);
      check("t3_wr1_cyc",  32'(wr_at(1)), 32'd15);
      check("t3_wr2_cyc",  32'(wr_at(2)), 32'd21);
      check("t3_done_cyc", 32'(done_first()), 32'd28);

      // Source starved for seven cycles while fetching the second byte.
      clear_pats();
      for (int i = 9; i <= 15; i++) valid_pat[i] = 1'b0;
      run(3, 8'h33, 1'b0);
      check("t4_wr1_cyc", 32'(wr_at(1)), 32'd17);
      check("t4_wr2_cyc", 32'(wr_at(2)), 32'd23);

      // Reset one cycle after the second write, then a fresh download.
      clear_pats();
      rst_at = 11;
      run(10, 8'h44, 1'b0);
      check("t5_wr_count",   32'(wr_cyc.size()), 32'd2);
      check("t5_done_count", 32'(done_cyc.size()), 32'd0);
      clear_pats();
      run(3, 8'h45, 1'b0);
      check("t5b_wr_count", 32'(wr_cyc.size()), 32'd3);
      check("t5b_addr0",    32'((wr_addr.size() > 0) ? wr_addr[0] : -1), 32'd0);

      // A start request in the gap must be ignored.
      clear_pats();
      start_pat[5] = 1'b1;
      idx_pat[5]   = 8'h77;
      run(5, 8'h01, 1'b0);
      check("t6_wr_count",   32'(wr_cyc.size()), 32'd5);
      check("t6_done_count", 32'(done_cyc.size()), 32'd1);
      @(negedge clk_sys);
      check("t6_index_hold", 32'(ioctl_index), 32'h01);

      // Randomized downloads with random stalls, stray starts and occasional reset.
      for (int r = 0; r < 14; r++) begin
         clear_pats();
         for (int i = 0; i < MAXC; i++) begin
            valid_pat[i] = ($urandom_range(3) != 0);
            wait_pat[i]  = ($urandom_range(3) == 0);
         end
         if ($urandom_range(3) == 0) rst_at = $urandom_range(1, 40);
         run($urandom_range(0, 12), 8'($urandom), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ioctl_loader.md
IOCTL_LOADER -- requirements
Module: ioctl_loader

Interface
REQ-001 Parameter WR_GAP, default 4, idle cycles after each ioctl_wr pulse; legal range 0..255.
REQ-002 Parameter PRE_CYC, default 2, cycles ioctl_download is high before the first write; legal range 1..255.
REQ-003 Parameter POST_CYC, default 2, cycles ioctl_download stays high after the last write; legal range 1..255.
REQ-004 clk_sys  in  1  single system clock; every register is clocked on its rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a download; sampled only in IDLE.
REQ-007 index  in  8  download index; latched on an accepted start.
REQ-008 length  in  25  byte count; latched on an accepted start.
REQ-009 s_valid  in  1  source byte valid.
REQ-010 s_data  in  8  source byte.
REQ-011 s_ready  out  1  loader accepts a source byte this cycle.
REQ-012 ioctl_wait  in  1  receiver back-pressure.
REQ-013 ioctl_download  out  1  download window active.
REQ-014 ioctl_index  out  8  latched index.
REQ-015 ioctl_wr  out  1  one-cycle write strobe.
REQ-016 ioctl_addr  out  25  byte address of the current write.
REQ-017 ioctl_dout  out  8  byte for the current write.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse when the download window closes.

Function
REQ-020 FSM states: IDLE, ARM, FETCH, WRITE, GAP, TAIL.
REQ-021 IDLE: start=1 latches index and length, clears the byte counter and moves to ARM; ioctl_download is high from the next cycle.
REQ-022 ARM: lasts PRE_CYC cycles, then goes to FETCH if the latched length is nonzero, otherwise to TAIL.
REQ-023 FETCH: s_ready = ~ioctl_wait; s_ready is 0 in every other state.
REQ-024 FETCH: on s_valid&s_ready, s_data is latched into ioctl_dout and the FSM moves to WRITE.
REQ-025 WRITE: lasts exactly 1 cycle with ioctl_wr=1; ioctl_addr equals the count of previously written bytes (first write at address 0).
REQ-026 Leaving WRITE: the byte counter increments; the FSM goes to GAP if WR_GAP>0, otherwise directly to the next-state decision of REQ-027.
REQ-027 GAP: counts WR_GAP cycles; the counter freezes while ioctl_wait=1; at expiry the FSM goes to FETCH if count<length, otherwise to TAIL.
REQ-028 Write spacing with s_valid=1 and ioctl_wait=0: one ioctl_wr pulse every WR_GAP+2 cycles.
REQ-029 ioctl_wait has no effect on a WRITE cycle already in progress.
REQ-030 ioctl_addr and ioctl_dout hold their values between writes and until the next start.
REQ-031 TAIL: lasts POST_CYC cycles; ioctl_download drops on the cycle after TAIL ends, in the same cycle as done=1, and the FSM returns to IDLE.
REQ-032 ioctl_download = 1 in ARM, FETCH, WRITE, GAP and TAIL; 0 in IDLE.
REQ-033 start is ignored while busy=1.
REQ-034 Counter and address are 25 bits; length up to 2^25-1 completes with no wrap.
REQ-035 Exactly length ioctl_wr pulses are issued per accepted start.

Reset
REQ-036 RESET=1 forces IDLE on the next edge, including in the middle of a download.
REQ-037 RESET values: ioctl_download=0, ioctl_wr=0, ioctl_addr=0, ioctl_dout=0, ioctl_index=0, s_ready=0, busy=0, done=0.
REQ-038 A reset mid-operation produces no done pulse; any source byte not yet accepted remains unconsumed.

Verification
REQ-039 Defaults, length=3, index=0, s_valid=1 with data 0xA0,0xA1,0xA2, ioctl_wait=0 -> start at cycle 0, download rises at cycle 1, wr pulses at cycles 4, 10, 16 with addr 0/1/2 and dout A0/A1/A2, done=1 and download falls at cycle 23.
REQ-040 length=0 -> no ioctl_wr pulse; download is high for PRE_CYC+POST_CYC cycles, then done.
REQ-041 ioctl_wait held high for 5 cycles during GAP after the 1st byte -> the 2nd wr pulse is delayed by exactly 5 cycles; data and address are unchanged.
REQ-042 s_valid low for 7 cycles in FETCH -> s_ready stays high, no wr pulse is issued, and the next byte is written at the correct address.
REQ-043 RESET asserted one cycle after the 2nd wr pulse of a length-10 download -> all outputs reach reset values next cycle, no done pulse; a new start then writes again from address 0.
REQ-044 start pulsed during GAP with length=5, index=0x01 -> ignored; the active download still issues exactly 5 writes and ioctl_index stays at its original value.
